// File: rtl/dmem_lsu.sv
// dmem_lsu - MEM-stage data memory load/store unit for the RISC-V pipeline.
//
// Holds a little-endian word array with byte, halfword and word stores
// driven by byte enables. Loads are sign- or zero-extended and come back
// after READ_LAT cycles. A valid/ready handshake lets the pipeline stall.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned H/W accesses are flagged and neither write nor read
//   undefined : low address bits are forced to alignment, misaligned tied 0
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_ready request handshake
//   MemRead, MemWrite   operation (both high = load)
//   a                   byte address
//   wd                  store data (low bytes used for SB/SH)
//   Funct3              access size / signedness
//   rd                  load result, held between load responses
//   resp_valid          one-cycle response pulse
//   misaligned          response flag, meaningful while resp_valid is high
module dmem_lsu #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  input  logic [2:0]            Funct3,
  output logic [DATA_W-1:0]     rd,
  output logic                  resp_valid,
  output logic                  misaligned
);

  localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t state, state_next;
  logic [2:0] cnt, cnt_next;
  logic [DM_ADDRESS-1:0] a_q;
  logic [2:0] f3_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic accept;
  logic [DM_ADDRESS-1:0] cur_a;
  logic [2:0] cur_f3;
  logic size_b, size_h;
  logic [1:0] lane;
  logic mis;
  logic [DM_ADDRESS-3:0] idx;
  logic [DATA_W-1:0] word;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [DATA_W-1:0] load_val;
  logic [3:0] be;
  logic [DATA_W-1:0] st_data;
  logic rd_load;

  assign accept = (state == IDLE) && req_valid && (MemRead || MemWrite);

  // In IDLE the access is described by the live inputs (accept edge, and
  // the READ_LAT=1 read); later cycles use the values latched at accept.
  assign cur_a  = (state == IDLE) ? a : a_q;
  assign cur_f3 = (state == IDLE) ? Funct3 : f3_q;

  // 011, 110 and 111 fall through to word size.
  assign size_b = (cur_f3[1:0] == 2'b00);
  assign size_h = (cur_f3[1:0] == 2'b01);

  always_comb begin
    lane = 2'b00;
    if (size_b)      lane = cur_a[1:0];
    else if (size_h) lane = {cur_a[1], 1'b0};
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = (size_h && cur_a[0]) || (!size_b && !size_h && (cur_a[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign idx  = cur_a[DM_ADDRESS-1:2];
  assign word = mem[idx];

  always_comb begin
    ld_byte = word[7:0];
    case (lane)
      2'd0:    ld_byte = word[7:0];
      2'd1:    ld_byte = word[15:8];
      2'd2:    ld_byte = word[23:16];
      default: ld_byte = word[31:24];
    endcase
    ld_half = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_val = word;
    if (size_b)      load_val = cur_f3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    else if (size_h) load_val = cur_f3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
  end

  // Store data is replicated across lanes so the enables alone pick the target.
  always_comb begin
    be      = 4'b1111;
    st_data = wd;
    if (size_b) begin
      be      = 4'b0001 << lane;
      st_data = {4{wd[7:0]}};
    end else if (size_h) begin
      be      = lane[1] ? 4'b1100 : 4'b0011;
      st_data = {2{wd[15:0]}};
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!MemRead || mis || (READ_LAT == 1)) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 3'(READ_LAT - 1);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 3'd1;
        if (cnt == 3'd1) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // rd is loaded on the edge that enters RESP, so it is valid during the
  // response cycle; misaligned responses clear it.
  assign rd_load = (state_next == RESP) && (((state == IDLE) && MemRead) || (state == WAIT) || mis);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      rd    <= '0;
      a_q   <= '0;
      f3_q  <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        a_q  <= a;
        f3_q <= Funct3;
      end
      if (rd_load) rd <= mis ? '0 : load_val;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   mis_q <= 1'b0;
    else if (state_next == RESP) mis_q <= mis;
  end

  assign misaligned = resp_valid && mis_q;
`else
  assign misaligned = 1'b0;
`endif

  // The array has no reset; committed writes survive a reset pulse.
  always_ff @(posedge clk) begin
    if (!reset && accept && !MemRead && !mis) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= st_data[8*k +: 8];
      end
    end
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised data-memory load/store unit for the RISC-V pipeline's MEM stage, replacing the single-cycle word-only data memory. It holds a little-endian word array and supports byte, halfword and word stores with byte enables. Loads are sign- or zero-extended, with a configurable read latency and a valid/ready request handshake so the pipeline can stall. Misaligned accesses are detected per access size.

## Interface
Parameters:
- DM_ADDRESS, 9: byte-address width; array depth = 2^(DM_ADDRESS-2) words.
- DATA_W, 32: data width; only 32 is supported.
- READ_LAT, 1: load latency in cycles, legal range 1..4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  unit can accept a request.
- MemRead  in  1  request is a load.
- MemWrite  in  1  request is a store.
- a  in  DM_ADDRESS  byte address.
- wd  in  DATA_W  store data; low bytes are used for SB/SH.
- Funct3  in  3  access size/sign.
- rd  out  DATA_W  load result.
- resp_valid  out  1  one-cycle pulse; the response for the accepted request.
- misaligned  out  1  response flag, valid only while resp_valid is high.

## Operation
- Accept: rising edge where req_valid && req_ready && (MemRead || MemWrite). Latch a, wd, Funct3 and op. If MemRead and MemWrite are both high, the request is a load and the write is ignored.
- If req_valid is high with neither MemRead nor MemWrite, nothing is accepted and the state stays IDLE.
- Funct3 decode:
  - 000 = B (signed load)
  - 001 = H (signed load)
  - 010 = W
  - 100 = BU
  - 101 = HU
  - Others (011, 110, 111) are treated as W.
  - For stores, 100 and 101 act as B and H.
- Byte lanes: byte k = data[8k+7:8k], selected by a[1:0].
- Halfword lane: selected by a[1].
- Store byte enables:
  - SB: one bit at a[1:0].
  - SH: 2'b11 shifted to lane a[1].
  - SW: 4'b1111.
- Store data is replicated so the enabled lanes carry wd's low byte or halfword.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW is unmodified.
- Array index = a[DM_ADDRESS-1:2]; it wraps naturally, with no out-of-range error.
- FSM:
  - IDLE: req_ready=1. On accept of a store or misaligned access, go to RESP. On accept of a load, go to WAIT with cnt=READ_LAT-1. If READ_LAT=1, go directly to RESP.
  - WAIT: req_ready=0. Decrement cnt; at cnt==1, go to RESP.
  - RESP: req_ready=0, resp_valid=1, then go to IDLE.
- rd is updated only in the RESP cycle of a load and holds its value otherwise. Store responses leave rd unchanged.
- The memory array is not cleared by reset.

## Timing
- Reset values: req_ready=1 (state IDLE), resp_valid=0, misaligned=0, rd=0, cnt=0.
- Store: bytes are written at the accept edge T. resp_valid is high in the cycle after T. Throughput is 1 store per 2 cycles.
- Load: resp_valid is high READ_LAT cycles after the accept edge, with rd valid in that cycle. Throughput is 1 load per READ_LAT+1 cycles.
- A load issued right after a store to the same word returns the new data, because the write completes before the load is accepted.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and any pending response is dropped (no resp_valid). Array writes already committed persist.
- req_valid held high during WAIT/RESP has no effect; the request is accepted on the first IDLE edge.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - Misaligned conditions: H with a[0]=1; W with a[1:0]!=0.
  - A misaligned request is accepted, but no array write occurs and no read result is used.
  - The response comes in the next cycle (RESP) with misaligned=1 and rd=0.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Low address bits are forced to alignment: a[0] is ignored for H, a[1:0] for W.
  - misaligned is tied to 0.
  - All accesses complete normally with normal latency.

## Test plan
- Reset, then SW 0xDEADBEEF at 0x010, then LW 0x010 with READ_LAT=1 → resp_valid in the cycle after the load accept, rd=0xDEADBEEF, req_ready low exactly 1 cycle per op.
- SB 0x80 at 0x013, then LB 0x013 → rd=0xFFFFFF80. LBU 0x013 → rd=0x00000080. LW 0x010 → rd=0x80ADBEEF.
- SH 0x1234 at 0x022, then LH 0x022 → rd=0x00001234. LW 0x020 → rd[31:16]=0x1234, lower half unchanged.
- READ_LAT=3: LW accepted at edge T → resp_valid exactly at T+3. Reset asserted at T+1 → no resp_valid, req_ready=1 immediately.
- With DMEM_MISALIGN_TRAP_EN, SW 0x11111111 at 0x031 → misaligned=1, rd=0, and LW 0x030 shows the old data. Without the macro, the same store writes word 0x030.
- MemRead and MemWrite both high with LW 0x010 → treated as a load, array unchanged, rd returns the stored word.
